// File: rtl/varredura_displays.sv
// Multiplexed 7-segment scanner with frame-synchronous double-buffered glyph loading.
// Optional blink support is compiled in when VARREDURA_PISCA_EN is defined.
module varredura_displays #(
    parameter int N_DIGITOS     = 4,
    parameter int DIV_VARREDURA = 50000,
    parameter int PISCA_QUADROS = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     carregar,
    input  logic [5*N_DIGITOS-1:0]   codigos,
    input  logic [N_DIGITOS-1:0]     pisca_mask,
    output logic [N_DIGITOS-1:0]     anodos,
    output logic                     a,
    output logic                     b,
    output logic                     c,
    output logic                     d,
    output logic                     e,
    output logic                     f,
    output logic                     g,
    output logic                     atualizado
);

    localparam int SLOT_W = (DIV_VARREDURA > 1) ? $clog2(DIV_VARREDURA) : 1;
    localparam int IDX_W  = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIV_VARREDURA - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITOS - 1);

    logic [SLOT_W-1:0]        slot_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic [5*N_DIGITOS-1:0]   codes_act_reg;
    logic [5*N_DIGITOS-1:0]   codes_sh_reg;
    logic [N_DIGITOS-1:0]     mask_act_reg;
    logic [N_DIGITOS-1:0]     mask_sh_reg;
    logic                     pendente_reg;
    logic                     atualizado_reg;

    logic                     slot_wrap;
    logic                     frame_end;
    logic                     pisca_off;
    logic [4:0]               code_arr [N_DIGITOS];
    logic [4:0]               code_cur;
    logic [6:0]               seg_next;

    assign slot_wrap = (slot_reg == SLOT_LAST);
    assign frame_end = slot_wrap && (idx_reg == IDX_LAST);

    function automatic logic [6:0] glyph(input logic [4:0] code);
        logic [6:0] s;  // {a,b,c,d,e,f,g}
        case (code)
            5'd0:    s = 7'b1111110;
            5'd1:    s = 7'b0110000;
            5'd2:    s = 7'b1101101;
            5'd3:    s = 7'b1111001;
            5'd4:    s = 7'b0110011;
            5'd5:    s = 7'b1011011;
            5'd6:    s = 7'b1011111;
            5'd7:    s = 7'b1110000;
            5'd8:    s = 7'b1111111;
            5'd9:    s = 7'b1111011;
            5'd10:   s = 7'b1110111;
            5'd11:   s = 7'b1001110;
            5'd12:   s = 7'b1001111;
            5'd13:   s = 7'b1000111;
            5'd14:   s = 7'b0001110;
            5'd15:   s = 7'b1100111;
            5'd16:   s = 7'b0110111;
            5'd17:   s = 7'b0111110;
            5'd18:   s = 7'b0000001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_reg       <= '0;
            idx_reg        <= '0;
            codes_act_reg  <= '1;
            codes_sh_reg   <= '1;
            mask_act_reg   <= '0;
            mask_sh_reg    <= '0;
            pendente_reg   <= 1'b0;
            atualizado_reg <= 1'b0;
        end else begin
            atualizado_reg <= 1'b0;
            slot_reg       <= slot_wrap ? '0 : slot_reg + 1'b1;
            if (slot_wrap) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
            // Active data only changes between frames, so a frame never mixes two loads.
            if (frame_end && pendente_reg) begin
                codes_act_reg  <= codes_sh_reg;
                mask_act_reg   <= mask_sh_reg;
                atualizado_reg <= 1'b1;
            end
            if (carregar) begin
                codes_sh_reg <= codigos;
                mask_sh_reg  <= pisca_mask;
                pendente_reg <= 1'b1;
            end else if (frame_end) begin
                pendente_reg <= 1'b0;
            end
        end
    end

`ifdef VARREDURA_PISCA_EN
    localparam int FR_W = (PISCA_QUADROS > 1) ? $clog2(PISCA_QUADROS) : 1;
    localparam logic [FR_W-1:0] FR_LAST = FR_W'(PISCA_QUADROS - 1);

    logic [FR_W-1:0] frame_reg;
    logic            fase_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_reg <= '0;
            fase_reg  <= 1'b1;
        end else if (frame_end) begin
            if (frame_reg == FR_LAST) begin
                frame_reg <= '0;
                fase_reg  <= ~fase_reg;
            end else begin
                frame_reg <= frame_reg + 1'b1;
            end
        end
    end

    assign pisca_off = ~fase_reg & mask_act_reg[idx_reg];
`else
    // Mask is still loaded so both builds share one load path; it never blanks here.
    assign pisca_off = mask_act_reg[idx_reg] & 1'b0;
`endif

    for (genvar gi = 0; gi < N_DIGITOS; gi++) begin : g_code
        assign code_arr[gi] = codes_act_reg[5*gi +: 5];
    end
    assign code_cur = code_arr[idx_reg];

    // Slot count 0 is a blanking clock to avoid ghosting between digits.
    always_comb begin
        anodos   = '0;
        seg_next = '0;
        if (slot_reg != '0) begin
            anodos[idx_reg] = 1'b1;
            if (!pisca_off) begin
                seg_next = glyph(code_cur);
            end
        end
    end

    assign {a, b, c, d, e, f, g} = seg_next;
    assign atualizado = atualizado_reg;

endmodule

// File: tb/tb_varredura_displays.sv
// Directed bench for varredura_displays with N_DIGITOS=4, DIV_VARREDURA=4, PISCA_QUADROS=2.
// Blink expectations follow VARREDURA_PISCA_EN as defined for the build.
module tb_varredura_displays;

    logic        clock = 1'b0;
    logic        reset;
    logic        carregar;
    logic [19:0] codigos;
    logic [3:0]  pisca_mask;
    logic [3:0]  anodos;
    logic        a, b, c, d, e, f, g;
    logic        atualizado;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_atu = 0;
    int n_lit = 0;

    localparam logic [6:0] S_BLANK = 7'b0000000;
    localparam logic [6:0] S_BC    = 7'b0110000;
    localparam logic [6:0] S_A     = 7'b1110111;
    localparam logic [6:0] S_C     = 7'b1001110;
    localparam logic [6:0] S_E     = 7'b1001111;
    localparam logic [6:0] S_8     = 7'b1111111;
    localparam logic [6:0] S_DASH  = 7'b0000001;
    localparam logic [6:0] S_7     = 7'b1110000;
    localparam logic [6:0] S_0     = 7'b1111110;
`ifdef VARREDURA_PISCA_EN
    localparam logic [6:0] S_BLINK = S_BLANK;
`else
    localparam logic [6:0] S_BLINK = S_8;
`endif

    wire [6:0] seg = {a, b, c, d, e, f, g};

    varredura_displays #(
        .N_DIGITOS    (4),
        .DIV_VARREDURA(4),
        .PISCA_QUADROS(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .carregar  (carregar),
        .codigos   (codigos),
        .pisca_mask(pisca_mask),
        .anodos    (anodos),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .g         (g),
        .atualizado(atualizado)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end else begin
            $display("ok   %s @cyc %0d: %0h", tag, cyc, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic load(input logic [19:0] codes, input logic [3:0] mask);
        carregar   = 1'b1;
        codigos    = codes;
        pisca_mask = mask;
        tick();
        carregar   = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] an, input logic [6:0] s);
        check_val({tag, "_an"}, 32'(anodos), 32'(an));
        check_val({tag, "_seg"}, 32'(seg), 32'(s));
    endtask

    initial begin
        reset      = 1'b1;
        carregar   = 1'b0;
        codigos    = '0;
        pisca_mask = '0;
        tick();
        tick();
        check_out("reset", 4'b0000, S_BLANK);
        check_val("reset_atu", 32'(atualizado), 32'd0);
        reset = 1'b0;
        cyc   = 0;

        // Scan order after reset with blank codes
        for (int k = 0; k <= 8; k++) begin
            check_out("scan", (k % 4 == 0) ? 4'b0000 : 4'(1 << (k / 4)), S_BLANK);
            if (k < 8) tick();
        end

        // Mid-frame load waits for the frame boundary
        go_to(9);
        load({5'd12, 5'd11, 5'd10, 5'd1}, 4'b0000);
        go_to(13); check_out("pend_d3", 4'b1000, S_BLANK);
        check_val("pend_atu", 32'(atualizado), 32'd0);
        go_to(15); check_val("pre_bound_atu", 32'(atualizado), 32'd0);
        go_to(16); check_val("bound_atu", 32'(atualizado), 32'd1);
        check_val("bound_an", 32'(anodos), 32'd0);
        go_to(17); check_out("ld_d0", 4'b0001, S_BC);
        check_val("post_atu", 32'(atualizado), 32'd0);
        go_to(21); check_out("ld_d1", 4'b0010, S_A);
        go_to(25); check_out("ld_d2", 4'b0100, S_C);
        go_to(29); check_out("ld_d3", 4'b1000, S_E);
        go_to(32); check_val("no_repeat_atu", 32'(atualizado), 32'd0);

        // Two strobes in one frame: last wins, one pulse
        go_to(33); load({4{5'd8}}, 4'b0000);
        go_to(37); load({4{5'd18}}, 4'b0000);
        check_out("hold_d1", 4'b0010, S_A);
        go_to(47); check_val("dbl_pre_atu", 32'(atualizado), 32'd0);
        go_to(48); check_val("dbl_atu", 32'(atualizado), 32'd1);
        go_to(49); check_out("dash_d0", 4'b0001, S_DASH);
        check_val("dbl_single", 32'(atualizado), 32'd0);
        go_to(53); check_out("dash_d1", 4'b0010, S_DASH);
        go_to(61); check_out("dash_d3", 4'b1000, S_DASH);
        go_to(64); check_val("dbl_next_atu", 32'(atualizado), 32'd0);

        // Strobe on the boundary clock with data already pending
        go_to(65); load({4{5'd7}}, 4'b0000);
        go_to(79); load({4{5'd0}}, 4'b0000);
        check_val("coinc_atu", 32'(atualizado), 32'd1);
        go_to(81); check_out("coinc_old_d0", 4'b0001, S_7);
        go_to(85); check_out("coinc_old_d1", 4'b0010, S_7);
        go_to(95); check_val("coinc_mid_atu", 32'(atualizado), 32'd0);
        go_to(96); check_val("coinc_2nd_atu", 32'(atualizado), 32'd1);
        go_to(97); check_out("coinc_new_d0", 4'b0001, S_0);
        go_to(112); check_val("coinc_end_atu", 32'(atualizado), 32'd0);

        // Blink on digit 0: lit 128..159, off 160..191, lit 192..223, off 224..
        go_to(113); load({4{5'd8}}, 4'b0001);
        go_to(128); check_val("blink_atu", 32'(atualizado), 32'd1);
        go_to(129); check_out("blink_lit_a", 4'b0001, S_8);
        go_to(145); check_out("blink_lit_b", 4'b0001, S_8);
        go_to(161); check_out("blink_off_a", 4'b0001, S_BLINK);
        go_to(165); check_out("blink_d1", 4'b0010, S_8);
        go_to(177); check_out("blink_off_b", 4'b0001, S_BLINK);
        go_to(193); check_out("blink_lit_c", 4'b0001, S_8);
        go_to(225); check_out("blink_off_c", 4'b0001, S_BLINK);

        // Reset mid-slot of digit 2 with a pending load, carregar also high
        go_to(226); load({4{5'd1}}, 4'b0000);
        go_to(233); check_val("pre_rst_an", 32'(anodos), 32'b0100);
        reset    = 1'b1;
        carregar = 1'b1;
        codigos  = {4{5'd2}};
        tick();
        check_out("rst_mid", 4'b0000, S_BLANK);
        check_val("rst_mid_atu", 32'(atualizado), 32'd0);
        carregar = 1'b0;
        tick();
        reset = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 40; k++) begin
            if (atualizado) n_atu++;
            if (seg != S_BLANK) n_lit++;
            if (k == 1) check_val("rst_restart_an", 32'(anodos), 32'b0001);
            if (k == 9) check_val("rst_d2_an", 32'(anodos), 32'b0100);
            tick();
        end
        check_val("rst_no_atu", 32'(n_atu), 32'd0);
        check_val("rst_no_lit", 32'(n_lit), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/varredura_displays.md
VARREDURA_DISPLAYS -- requirements
Module: varredura_displays

Interface
REQ-001 Parameter N_DIGITOS, default 4, number of multiplexed 7-segment digits (legal 1..8) SHALL be supported.
REQ-002 Parameter DIV_VARREDURA, default 50000, clocks per digit slot (legal >=2) SHALL be supported.
REQ-003 Parameter PISCA_QUADROS, default 64, full scan frames per blink half-period (legal >=1) SHALL be supported.
REQ-004 clock  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the clock edge.
REQ-006 carregar  input  1  one-clock load strobe for codigos and pisca_mask.
REQ-007 codigos  input  5*N_DIGITOS  glyph code per digit; digit i occupies bits [5i+4:5i].
REQ-008 pisca_mask  input  N_DIGITOS  bit i=1 marks digit i as blinking.
REQ-009 anodos  output  N_DIGITOS  one-hot active-high digit enable, bit i drives digit i.
REQ-010 a, b, c, d, e, f, g  output  1 each  active-high segment drives for the currently enabled digit.
REQ-011 atualizado  output  1  one-clock pulse when pending data becomes the displayed data.

Function
REQ-012 Outputs SHALL be derived from registered state only; no combinational path from any input to any output.
REQ-013 Slot counter SHALL count 0..DIV_VARREDURA-1 and wrap to 0; on wrap, digit index SHALL advance i -> i+1, N_DIGITOS-1 -> 0.
REQ-014 Slot count 0 SHALL be a blanking clock: anodos all 0; counts 1..DIV_VARREDURA-1 SHALL drive anodos bit i only.
REQ-015 Segments SHALL show the glyph of active code for digit i; during blanking they SHALL be 0.
REQ-016 Glyph table: codes 0-9 SHALL be standard decimal digits (6 includes a, 7 = a,b,c, 9 includes d).
REQ-017 Glyph table: 10 A=abcefg, 11 C=adef, 12 E=adefg, 13 F=aefg, 14 L=def, 15 P=abefg, 16 H=bcefg, 17 U=bcdef, 18 '-'=g; codes 19-31 SHALL be blank.
REQ-018 carregar=1 SHALL capture codigos and pisca_mask into a shadow register and set pendente on that clock.
REQ-019 Shadow SHALL copy into the active register only at the clock where digit index wraps N_DIGITOS-1 -> 0, if pendente=1; pendente SHALL clear and atualizado SHALL pulse for exactly that clock.
REQ-020 Data SHALL never change within a frame; a frame SHALL be displayed entirely from one active register value.
REQ-021 Multiple carregar strobes before a frame boundary: last one SHALL win; only one atualizado pulse SHALL result.
REQ-022 carregar coinciding with the frame-boundary clock: the previous shadow value SHALL be applied, the new value SHALL be captured into shadow, and pendente SHALL remain 1 for the next boundary.
REQ-023 Frame counter SHALL count completed frames 0..PISCA_QUADROS-1; on its wrap, blink phase fase SHALL toggle.
REQ-024 When fase=0 and the active pisca_mask bit of the enabled digit is 1, segments SHALL be 0 while anodos is still driven.
REQ-025 N_DIGITOS=1: index stays 0, every slot wrap is a frame boundary.

Reset
REQ-026 While reset=1 at a clock edge: slot counter, digit index and frame counter SHALL be 0; fase SHALL be 1; pendente and atualizado SHALL be 0.
REQ-027 Reset SHALL load code 31 (blank) into all active and shadow codes and 0 into both masks; anodos and segments SHALL read 0 during and on the first clock after reset.
REQ-028 Reset mid-frame SHALL discard pending shadow data and restart at digit 0, slot count 0; reset SHALL take priority over carregar.

Configuration
REQ-029 Macro VARREDURA_PISCA_EN defined: blink logic per REQ-023/REQ-024 SHALL be compiled in.
REQ-030 Macro VARREDURA_PISCA_EN undefined: frame counter and fase SHALL be absent, pisca_mask SHALL be accepted but ignored, and digits SHALL never blank for blinking; all other behaviour unchanged.

Verification (N_DIGITOS=4, DIV_VARREDURA=4, PISCA_QUADROS=2)
REQ-031 Reset release, no load -> anodos sequence 0000,0001,0001,0001,0000,0010... every 4 clocks; segments 0 throughout (blank codes).
REQ-032 carregar with codigos={12,11,10,1} (digit3..0) mid-frame -> no change until next index wrap 3->0; atualizado 1 clock there; digit0 segments=bc, digit1=abcefg, digit2=adef, digit3=adefg.
REQ-033 Two strobes in one frame (codes all 8, then all 18) -> single atualizado; all digits show g only.
REQ-034 carregar exactly on boundary clock with pending data -> old shadow applied, atualizado=1, a second atualizado pulse at the following boundary with the new data.
REQ-035 pisca_mask=0001, macro defined -> digit0 segments 0 for 2 frames, lit 2 frames, repeating, anodos unaffected; macro undefined -> digit0 always lit.
REQ-036 reset asserted mid-slot of digit 2 with pending load -> next clock all outputs 0, pending data never displayed, atualizado never pulses.
